// File: rtl/ssd_pkg.sv
// Shared types and constants for the score seven-segment driver.
// Segment patterns are active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg}.
package ssd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [15:0] SCORE_MAX_DISP = 16'd9999;
    localparam logic [15:0] BCD_SATURATED  = 16'h9999;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (double-dabble, one bit per cycle).
// bcd is valid while done is high and saturates to 9999 for larger inputs.
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    conv_state_e state_q, state_d;
    logic [15:0] shift_bin_q, shift_bin_d;
    logic [19:0] shift_bcd_q, shift_bcd_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        sat_q, sat_d;
    logic [19:0] bcd_adj;

    // Add-3 correction on every digit that would overflow past 9 after the shift.
    always_comb begin
        bcd_adj = shift_bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (shift_bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = shift_bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_bin_d = shift_bin_q;
        shift_bcd_d = shift_bcd_q;
        bit_cnt_d   = bit_cnt_q;
        sat_d       = sat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shift_bin_d = bin;
                shift_bcd_d = '0;
                bit_cnt_d   = '0;
                sat_d       = (bin > SCORE_MAX_DISP);
                state_d     = StShift;
            end
            StShift: begin
                {shift_bcd_d, shift_bin_d} = {bcd_adj, shift_bin_q} << 1;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            shift_bin_q <= '0;
            shift_bcd_q <= '0;
            bit_cnt_q   <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_bin_q <= shift_bin_d;
            shift_bcd_q <= shift_bcd_d;
            bit_cnt_q   <= bit_cnt_d;
            sat_q       <= sat_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign bcd  = sat_q ? BCD_SATURATED : shift_bcd_q[15:0];

endmodule

// File: rtl/score_ssd_driver.sv
// Score to four-digit multiplexed seven-segment driver (active-low anodes and segments).
// Define SSD_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module score_ssd_driver
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] score,
    output logic [3:0]  anode,
    output logic [6:0]  ssdOut,
    output logic        dp
);

    localparam logic [REFRESH_BITS-1:0] CntOne = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic [REFRESH_BITS-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [15:0] last_score_q, last_score_d;
    logic [15:0] disp_bcd_q, disp_bcd_d;
    logic        first_q, first_d;
    logic        load_q, load_d;
    logic [3:0]  anode_q, anode_d;
    logic [6:0]  ssd_q, ssd_d;

    logic        start;
    logic        conv_busy;
    logic        conv_done;
    logic [15:0] conv_bcd;
    logic [1:0]  idx;
    logic [3:0]  digit;

    // first_q forces one conversion after reset even when score matches the cleared last_score.
    assign start = first_q | (score != last_score_q);

    bin2bcd_seq u_bin2bcd (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start),
        .bin   (score),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // load_q marks the cycle the converter spends in LOAD, so last_score tracks what it captured.
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + CntOne;
        first_d       = first_q;
        load_d        = start & ~conv_busy;
        last_score_d  = last_score_q;
        disp_bcd_d    = disp_bcd_q;
        if (start && !conv_busy) begin
            first_d = 1'b0;
        end
        if (load_q) begin
            last_score_d = score;
        end
        if (conv_done) begin
            disp_bcd_d = conv_bcd;
        end
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [3:0] blank_mask;

    always_comb begin
        blank_mask    = 4'b0000;
        blank_mask[3] = (disp_bcd_q[15:12] == 4'd0);
        blank_mask[2] = blank_mask[3] & (disp_bcd_q[11:8] == 4'd0);
        blank_mask[1] = blank_mask[2] & (disp_bcd_q[7:4] == 4'd0);
    end
`endif

    always_comb begin
        idx     = refresh_cnt_q[REFRESH_BITS-1 -: 2];
        digit   = disp_bcd_q[{idx, 2'b00} +: 4];
        anode_d = ~(4'b0001 << idx);
        ssd_d   = seg_decode(digit);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (blank_mask[idx]) begin
            anode_d = 4'b1111;
            ssd_d   = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            refresh_cnt_q <= '0;
            last_score_q  <= '0;
            disp_bcd_q    <= '0;
            first_q       <= 1'b1;
            load_q        <= 1'b0;
            anode_q       <= 4'b1110;
            ssd_q         <= SEG_0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            last_score_q  <= last_score_d;
            disp_bcd_q    <= disp_bcd_d;
            first_q       <= first_d;
            load_q        <= load_d;
            anode_q       <= anode_d;
            ssd_q         <= ssd_d;
        end
    end

    assign anode  = anode_q;
    assign ssdOut = ssd_q;
    assign dp     = 1'b1;

endmodule

// File: tb/tb_score_ssd_driver.sv
// Randomized bench for score_ssd_driver against a decimal-arithmetic display model.
module tb_score_ssd_driver;

    localparam int RB   = 4;
    localparam int SCAN = 1 << RB;
    localparam int DWELL = SCAN / 4;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    localparam int POW10 [4] = '{1, 10, 100, 1000};

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] score = 16'd0;
    logic [3:0]  anode;
    logic [6:0]  ssdOut;
    logic        dp;

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset release, conversion schedule, value on display.
    int          edge_n;
    bit          m_busy;
    bit          m_first;
    int          m_load_edge;
    logic [15:0] m_last;
    logic [15:0] m_cap;
    int          m_shown;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_seg;

    score_ssd_driver #(
        .REFRESH_BITS (RB)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .score  (score),
        .anode  (anode),
        .ssdOut (ssdOut),
        .dp     (dp)
    );

    always #5 Clk = ~Clk;

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_reset();
        edge_n    = 0;
        m_busy    = 1'b0;
        m_first   = 1'b1;
        m_last    = 16'd0;
        m_cap     = 16'd0;
        m_shown   = 0;
        exp_anode = 4'b1110;
        exp_seg   = 7'b0000001;
    endtask

    // Advance the model by one clock edge; score is the value present just before it.
    task automatic model_edge();
        int  idx;
        int  dig;
        bit  blank;
        edge_n++;
        idx   = ((edge_n - 1) % SCAN) / DWELL;
        dig   = (m_shown / POW10[idx]) % 10;
        blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        blank = (idx > 0) && (m_shown < POW10[idx]);
`endif
        if (blank) begin
            exp_anode = 4'b1111;
            exp_seg   = 7'b1111111;
        end else begin
            exp_anode = 4'(~(4'b0001 << idx));
            exp_seg   = SEG_TAB[dig];
        end
        if (!m_busy) begin
            if (m_first || score != m_last) begin
                m_busy      = 1'b1;
                m_first     = 1'b0;
                m_load_edge = edge_n + 1;
            end
        end else if (edge_n == m_load_edge) begin
            m_cap  = score;
            m_last = score;
        end else if (edge_n == m_load_edge + 17) begin
            m_shown = (m_cap > 16'd9999) ? 9999 : int'(m_cap);
            m_busy  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_value("anode", 16'(anode), 16'(exp_anode));
        check_value("ssdOut", 16'(ssdOut), 16'(exp_seg));
        check_value("dp", 16'(dp), 16'd1);
        check_value("anode_low_count", 16'($countones(~anode)), 16'($countones(~exp_anode)));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            model_edge();
            @(negedge Clk);
            check_outputs();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, "_anode"}, 16'(anode), 16'h000e);
        check_value({tag, "_ssdOut"}, 16'(ssdOut), 16'h0001);
        check_value({tag, "_dp"}, 16'(dp), 16'd1);
    endtask

    // Assert reset asynchronously, hold a few cycles, release on a falling edge.
    task automatic do_reset();
        #2;
        Reset = 1'b1;
        #1;
        check_reset_values("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_reset_values("rst_hold");
        end
        Reset = 1'b0;
        model_reset();
        #1;
        check_reset_values("rst_release");
    endtask

    initial begin
        int hold;
        int kind;
        bit hit;
        model_reset();
        score = 16'd0;
        @(negedge Clk);
        do_reset();
        step(40);

        score = 16'd1234;
        step(3 * SCAN + 30);

        // Reset mid-scan with score 0.
        score = 16'd0;
        step(7);
        do_reset();
        step(2 * SCAN + 30);

        score = 16'd12000;
        step(60);
        score = 16'd65535;
        step(60);

        // Change score five edges after the LOAD capture.
        score = 16'd100;
        hit   = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step(1);
            hit = m_busy && (edge_n == m_load_edge + 5);
        end
        check_value("mid_change_reached", 16'(hit), 16'd1);
        score = 16'd250;
        step(80);

        score = 16'd7;
        step(60);
        score = 16'd0;
        step(60);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                score = 16'($urandom_range(0, 9));
            end else if (kind == 1) begin
                score = 16'($urandom_range(0, 9999));
            end else begin
                score = 16'($urandom_range(0, 65535));
            end
            hold = $urandom_range(1, 40);
            step(hold);
        end
        step(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
